// File: rtl/sram_bridge_1x2_if.sv
// Sram-like request/response bundle shared by the CPU-side port and both slave ports.
// The requester drives req and the request fields; the responder drives acceptance and data.
interface sram_bridge_1x2_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req,
    output wr,
    output size,
    output addr,
    output wdata,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  wr,
    input  size,
    input  addr,
    input  wdata,
    output addr_ok,
    output data_ok,
    output rdata
  );
endinterface

// File: rtl/sram_bridge_1x2.sv
// One-to-two sram-like bridge: the address decode selects main memory (s0) or the confreg
// window (s1). An outstanding-request tracker keeps responses in order across slaves.
module sram_bridge_1x2 #(
  parameter int unsigned MAX_OUT   = 4,
  parameter logic [31:0] CONF_MASK = 32'hffff_0000,
  parameter logic [31:0] CONF_BASE = 32'h1faf_0000
) (
  input  logic              clk,
  input  logic              rst,
  sram_bridge_1x2_if.slave  m,
  sram_bridge_1x2_if.master s0,
  sram_bridge_1x2_if.master s1
);

  localparam int unsigned     CntW   = $clog2(MAX_OUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cur_sel_q, cur_sel_d;
  logic            tgt;
  logic            can_issue;
  logic            accept;
  logic            respond;

  // Only one slave may own outstanding requests; switching waits for a full drain.
  always_comb begin
    tgt       = ((m.addr & CONF_MASK) == CONF_BASE);
    can_issue = (cnt_q == '0) | ((cnt_q < CntMax) & (tgt == cur_sel_q));
  end

  // Request path: request fields are broadcast; only req is steered.
  always_comb begin
    s0.req   = m.req & ~tgt & can_issue;
    s1.req   = m.req &  tgt & can_issue;
    s0.wr    = m.wr;
    s1.wr    = m.wr;
    s0.size  = m.size;
    s1.size  = m.size;
    s0.addr  = m.addr;
    s1.addr  = m.addr;
    s0.wdata = m.wdata;
    s1.wdata = m.wdata;
    m.addr_ok = can_issue & (tgt ? s1.addr_ok : s0.addr_ok);
  end

  // Response path: responses from the non-owning slave or with nothing pending are dropped.
  always_comb begin
    m.data_ok = (cnt_q != '0) & (cur_sel_q ? s1.data_ok : s0.data_ok);
    m.rdata   = cur_sel_q ? s1.rdata : s0.rdata;
  end

  always_comb begin
    accept    = m.req & m.addr_ok;
    respond   = m.data_ok;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    if (accept) begin
      cur_sel_d = tgt;
    end
    unique case ({accept, respond})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      cur_sel_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  cnt_bounded: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntMax);

endmodule

// File: tb/tb_sram_bridge_1x2.sv
// Scoreboard bench for sram_bridge_1x2: directed scenarios plus randomized traffic, checked
// against an in-order queue model of outstanding requests.
module tb_sram_bridge_1x2;

  localparam int unsigned MAX_OUT   = 4;
  localparam logic [31:0] CONF_MASK = 32'hffff_0000;
  localparam logic [31:0] CONF_BASE = 32'h1faf_0000;

  typedef struct {
    int          cyc;
    bit          s0r;
    bit          s1r;
    bit          aok;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    logic [1:0]  size;
  } cyc_rec_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sram_bridge_1x2_if m_if ();
  sram_bridge_1x2_if s0_if ();
  sram_bridge_1x2_if s1_if ();

  sram_bridge_1x2 #(
    .MAX_OUT  (MAX_OUT),
    .CONF_MASK(CONF_MASK),
    .CONF_BASE(CONF_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m  (m_if),
    .s0 (s0_if),
    .s1 (s1_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit mon_en      = 1'b0;

  // Reference model: targets of accepted-but-unanswered requests, oldest first.
  bit       own[$];
  bit       last = 1'b0;
  cyc_rec_t cq[$];
  rsp_rec_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit req, input logic [31:0] addr, input bit wr,
                      input logic [1:0] size, input logic [31:0] wdata,
                      input bit a0, input bit a1, input bit d0, input bit d1,
                      input logic [31:0] r0, input logic [31:0] r1);
    bit       tgt, issue, acc, resp;
    int       n;
    cyc_rec_t c;
    @(posedge clk);
    #1;
    cyc++;
    mon_en         = 1'b1;
    m_if.req       = req;
    m_if.addr      = addr;
    m_if.wr        = wr;
    m_if.size      = size;
    m_if.wdata     = wdata;
    s0_if.addr_ok  = a0;
    s1_if.addr_ok  = a1;
    s0_if.data_ok  = d0;
    s1_if.data_ok  = d1;
    s0_if.rdata    = r0;
    s1_if.rdata    = r1;

    tgt   = ((addr & CONF_MASK) == CONF_BASE);
    n     = own.size();
    issue = (n == 0) || (n < int'(MAX_OUT) && own[n-1] == tgt);
    acc   = req && issue && (tgt ? a1 : a0);
    resp  = (n > 0) && (own[0] ? d1 : d0);

    c = '{cyc, req && issue && !tgt, req && issue && tgt, issue && (tgt ? a1 : a0),
          last ? r1 : r0, addr, wdata, wr, size};
    cq.push_back(c);
    if (resp) begin
      rq.push_back('{cyc, own[0] ? r1 : r0});
      void'(own.pop_front());
    end
    if (acc) begin
      own.push_back(tgt);
      last = tgt;
    end
  endtask

  // Async reset between clock edges while an s0 response is presented and an s1 request waits.
  task automatic mid_reset();
    int n;
    bit exp_ok, exp_dok;
    @(posedge clk);
    #2;
    mon_en        = 1'b0;
    m_if.req      = 1'b1;
    m_if.addr     = 32'h1faf_0040;
    m_if.wr       = 1'b0;
    s0_if.addr_ok = 1'b0;
    s1_if.addr_ok = 1'b1;
    s0_if.data_ok = 1'b1;
    s1_if.data_ok = 1'b0;
    #1;
    n       = own.size();
    exp_ok  = (n == 0) || (n < int'(MAX_OUT) && last);
    exp_dok = (n > 0) && !last;
    chk("pre_reset addr_ok", 32'(m_if.addr_ok), 32'(exp_ok));
    chk("pre_reset data_ok", 32'(m_if.data_ok), 32'(exp_dok));
    rst = 1'b1;
    #1;
    chk("async_reset data_ok", 32'(m_if.data_ok), 32'd0);
    chk("async_reset addr_ok", 32'(m_if.addr_ok), 32'd1);
    chk("async_reset s1_req", 32'(s1_if.req), 32'd1);
    chk("async_reset s0_req", 32'(s0_if.req), 32'd0);
    @(posedge clk);
    #3;
    m_if.req      = 1'b0;
    s0_if.data_ok = 1'b0;
    rst           = 1'b0;
    own.delete();
    last = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc_rec_t e;
    rsp_rec_t r;
    if (mon_en && cq.size() > 0) begin
      e = cq.pop_front();
      chk("s0_req", 32'(s0_if.req), 32'(e.s0r));
      chk("s1_req", 32'(s1_if.req), 32'(e.s1r));
      chk("m_addr_ok", 32'(m_if.addr_ok), 32'(e.aok));
      chk("m_rdata route", m_if.rdata, e.rdata);
      chk("s0_addr", s0_if.addr, e.addr);
      chk("s1_wdata", s1_if.wdata, e.wdata);
      chk("s0_wr/s1_size", {29'd0, s0_if.wr, s1_if.size}, {29'd0, e.wr, e.size});
    end
    if (mon_en) begin
      if (m_if.data_ok) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          r = rq.pop_front();
          chk("response rdata", m_if.rdata, r.data);
        end else begin
          chk("unexpected m_data_ok", 32'(m_if.data_ok), 32'd0);
        end
      end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("missing m_data_ok", 32'(m_if.data_ok), 32'd1);
      end
    end
  end

  initial begin
    m_if.req = 1'b0; m_if.wr = 1'b0; m_if.size = 2'd0; m_if.addr = '0; m_if.wdata = '0;
    s0_if.addr_ok = 1'b0; s0_if.data_ok = 1'b0; s0_if.rdata = '0;
    s1_if.addr_ok = 1'b0; s1_if.data_ok = 1'b0; s1_if.rdata = '0;
    s0_if.data_ok = 1'b1;
    #2;
    chk("reset m_data_ok", 32'(m_if.data_ok), 32'd0);
    chk("reset s0_req idle", 32'(s0_if.req), 32'd0);
    chk("reset s1_req idle", 32'(s1_if.req), 32'd0);
    m_if.req = 1'b1;
    s0_if.addr_ok = 1'b1;
    #1;
    chk("reset s0_req with m_req", 32'(s0_if.req), 32'd1);
    chk("reset m_addr_ok", 32'(m_if.addr_ok), 32'd1);
    m_if.req = 1'b0;
    s0_if.data_ok = 1'b0;
    #19 rst = 1'b0;

    // single read to s0
    step(1, 32'h0000_1000, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    step(0, 32'h0000_1000, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    step(0, 32'h0000_1000, 0, 2, 0, 1, 0, 1, 0, 32'hdead_beef, 0);
    // confreg write
    step(1, 32'h1faf_f000, 1, 2, 32'h0000_00ff, 0, 1, 0, 0, 0, 0);
    step(0, 32'h1faf_f000, 0, 2, 0, 0, 1, 0, 1, 0, 32'h1234_5678);
    // slave switch stall
    step(1, 32'h0000_2000, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'h0000_2004, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'h1faf_0004, 0, 2, 0, 1, 1, 0, 0, 0, 0);
    step(1, 32'h1faf_0004, 0, 2, 0, 1, 1, 1, 0, 32'h0000_0a01, 0);
    step(1, 32'h1faf_0004, 0, 2, 0, 1, 1, 1, 0, 32'h0000_0a02, 0);
    step(1, 32'h1faf_0004, 0, 2, 0, 1, 1, 0, 0, 0, 0);
    step(0, 32'h1faf_0004, 0, 2, 0, 1, 1, 0, 1, 0, 32'h0000_0b01);
    // fill to MAX_OUT, no bypass on a same-cycle response
    for (int i = 0; i < 4; i++) step(1, 32'h0000_3000 + 32'(i * 4), 0, 2, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'h0000_3010, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c01, 0);
    step(1, 32'h0000_3010, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    step(0, 32'h0000_3010, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c02, 0);
    step(1, 32'h0000_3018, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c03, 0);
    // stray responses
    step(0, 32'h0000_3018, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c04, 0);
    step(0, 32'h0000_3018, 0, 2, 0, 1, 0, 0, 1, 0, 32'h0000_0d01);
    step(0, 32'h0000_3018, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c05, 0);
    step(0, 32'h0000_3018, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c06, 0);
    step(0, 32'h0000_3018, 0, 2, 0, 1, 0, 1, 0, 32'h0000_0c07, 0);
    // reset with three s0 requests outstanding
    for (int i = 0; i < 3; i++) step(1, 32'h0000_4000 + 32'(i * 4), 0, 2, 0, 1, 0, 0, 0, 0, 0);
    mid_reset();
    step(1, 32'h1faf_0020, 0, 2, 0, 0, 1, 1, 0, 32'h0000_0e01, 0);
    step(0, 32'h1faf_0020, 0, 2, 0, 0, 1, 1, 1, 32'h0000_0e02, 32'h0000_0f01);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      case ($urandom_range(3))
        0:       a = CONF_BASE | ($urandom & 32'h0000_fffc);
        1:       a = (($urandom_range(1) == 0) ? 32'h1fae_0000 : 32'h1fbf_0000)
                     | ($urandom & 32'h0000_fffc);
        default: a = $urandom & 32'h00ff_fffc;
      endcase
      step($urandom_range(99) < 70, a, 1'($urandom_range(1)), 2'($urandom_range(2)), $urandom,
           $urandom_range(99) < 70, $urandom_range(99) < 70,
           $urandom_range(99) < 40, $urandom_range(99) < 40, $urandom, $urandom);
      if (i == 700) mid_reset();
    end

    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(cq.size() + rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
